// File: rtl/airi5c_float_round.sv
// Final rounding and packing stage for single-precision results.
// Denormalizes tiny results, applies the rounding mode, flags exceptions.
module airi5c_float_round (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        kill,
  input  logic        load,
  input  logic [23:0] man,
  input  logic [9:0]  Exp,
  input  logic        sgn,
  input  logic        round_bit,
  input  logic        sticky_bit,
  input  logic        IV,
  input  logic        final_res,
  input  logic [2:0]  rm,
  output logic [31:0] float_out,
  output logic        NV,
  output logic        OF,
  output logic        UF,
  output logic        NX,
  output logic        ready
);

  typedef enum logic [1:0] {IDLE, DENORM, ROUND} state_t;

  state_t state, state_n;

  logic [23:0] m_q, m_n;
  logic        r_q, r_n, s_q, s_n;
  logic        sgn_q, sgn_n, iv_q, iv_n, den_q, den_n;
  logic [2:0]  rm_q, rm_n;
  logic [4:0]  cnt_q, cnt_n;
  logic signed [10:0] e_q, e_n;

  logic [31:0] out_n;
  logic        nv_n, of_n, uf_n, nx_n, rdy_n;

  logic signed [10:0] biased, shamt, e_f;
  logic [4:0]  cnt_ld;
  logic        last, r_in, s_in, inc, ovf, to_inf, nx_r;
  logic [23:0] m_in, m_f;
  logic [24:0] sum;
  logic [31:0] res;

  assign biased = $signed({Exp[9], Exp}) + 11'sd127;
  assign shamt  = 11'sd1 - biased;
  assign cnt_ld = (shamt > 11'sd26) ? 5'd26 : shamt[4:0];

  // The last denormalizing shift is folded into the rounding cycle.
  assign last = (state == DENORM);
  assign m_in = last ? {1'b0, m_q[23:1]} : m_q;
  assign r_in = last ? m_q[0] : r_q;
  assign s_in = last ? (s_q | r_q) : s_q;
  assign nx_r = r_in | s_in;

  always_comb begin
    case (rm_q)
      3'b001:  inc = 1'b0;
      3'b010:  inc = sgn_q & nx_r;
      3'b011:  inc = !sgn_q & nx_r;
      3'b100:  inc = r_in;
      default: inc = r_in & (s_in | m_in[0]);
    endcase
    case (rm_q)
      3'b001:  to_inf = 1'b0;
      3'b010:  to_inf = sgn_q;
      3'b011:  to_inf = !sgn_q;
      default: to_inf = 1'b1;
    endcase
  end

  assign sum = {1'b0, m_in} + {24'd0, inc};

  always_comb begin
    m_f = sum[23:0];
    e_f = e_q;
    if (sum[24]) begin
      m_f = 24'h800000;
      e_f = e_q + 11'sd1;
    end else if (e_q == 11'sd0 && sum[23]) begin
      e_f = 11'sd1;
    end
  end

  assign ovf = (e_f >= 11'sd255);
  assign res = ovf ? (to_inf ? {sgn_q, 8'hFF, 23'h0}
                             : {sgn_q, 31'h7F7FFFFF})
                   : {sgn_q, e_f[7:0], m_f[22:0]};

  always_comb begin
    state_n = state;
    m_n     = m_q;
    r_n     = r_q;
    s_n     = s_q;
    sgn_n   = sgn_q;
    iv_n    = iv_q;
    den_n   = den_q;
    rm_n    = rm_q;
    cnt_n   = cnt_q;
    e_n     = e_q;
    out_n   = float_out;
    nv_n    = NV;
    of_n    = OF;
    uf_n    = UF;
    nx_n    = NX;
    rdy_n   = 1'b0;
    if (kill) begin
      state_n = IDLE;
      m_n     = '0;
      r_n     = 1'b0;
      s_n     = 1'b0;
      sgn_n   = 1'b0;
      iv_n    = 1'b0;
      den_n   = 1'b0;
      rm_n    = '0;
      cnt_n   = '0;
      e_n     = '0;
      out_n   = '0;
      nv_n    = 1'b0;
      of_n    = 1'b0;
      uf_n    = 1'b0;
      nx_n    = 1'b0;
    end else if (load) begin
      if (final_res) begin
        state_n = IDLE;
        out_n   = {sgn, Exp[7:0], man[22:0]};
        nv_n    = IV;
        of_n    = 1'b0;
        uf_n    = 1'b0;
        nx_n    = 1'b0;
        rdy_n   = 1'b1;
      end else begin
        m_n   = man;
        r_n   = round_bit;
        s_n   = sticky_bit;
        sgn_n = sgn;
        iv_n  = IV;
        rm_n  = rm;
        if (biased >= 11'sd1) begin
          state_n = ROUND;
          e_n     = biased;
          den_n   = 1'b0;
          cnt_n   = '0;
        end else begin
          state_n = DENORM;
          e_n     = '0;
          den_n   = 1'b1;
          cnt_n   = cnt_ld;
        end
      end
    end else begin
      case (state)
        DENORM: begin
          if (cnt_q == 5'd1) begin
            state_n = IDLE;
            out_n   = res;
            nv_n    = iv_q;
            of_n    = ovf;
            uf_n    = den_q & nx_r;
            nx_n    = nx_r | ovf;
            rdy_n   = 1'b1;
          end else begin
            m_n   = m_in;
            r_n   = r_in;
            s_n   = s_in;
            cnt_n = cnt_q - 5'd1;
          end
        end
        ROUND: begin
          state_n = IDLE;
          out_n   = res;
          nv_n    = iv_q;
          of_n    = ovf;
          uf_n    = den_q & nx_r;
          nx_n    = nx_r | ovf;
          rdy_n   = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state     <= IDLE;
      m_q       <= '0;
      r_q       <= 1'b0;
      s_q       <= 1'b0;
      sgn_q     <= 1'b0;
      iv_q      <= 1'b0;
      den_q     <= 1'b0;
      rm_q      <= '0;
      cnt_q     <= '0;
      e_q       <= '0;
      float_out <= '0;
      NV        <= 1'b0;
      OF        <= 1'b0;
      UF        <= 1'b0;
      NX        <= 1'b0;
      ready     <= 1'b0;
    end else begin
      state     <= state_n;
      m_q       <= m_n;
      r_q       <= r_n;
      s_q       <= s_n;
      sgn_q     <= sgn_n;
      iv_q      <= iv_n;
      den_q     <= den_n;
      rm_q      <= rm_n;
      cnt_q     <= cnt_n;
      e_q       <= e_n;
      float_out <= out_n;
      NV        <= nv_n;
      OF        <= of_n;
      UF        <= uf_n;
      NX        <= nx_n;
      ready     <= rdy_n;
    end
  end

endmodule

// File: tb/tb_airi5c_float_round.sv
// Directed bench for airi5c_float_round.
// Flags are compared as {NV, OF, UF, NX}.
module tb_airi5c_float_round;

  logic        clk = 1'b0;
  logic        n_reset, kill, load;
  logic [23:0] man;
  logic [9:0]  Exp;
  logic        sgn, round_bit, sticky_bit, IV, final_res;
  logic [2:0]  rm;
  logic [31:0] float_out;
  logic        NV, OF, UF, NX, ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  airi5c_float_round dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .kill       (kill),
    .load       (load),
    .man        (man),
    .Exp        (Exp),
    .sgn        (sgn),
    .round_bit  (round_bit),
    .sticky_bit (sticky_bit),
    .IV         (IV),
    .final_res  (final_res),
    .rm         (rm),
    .float_out  (float_out),
    .NV         (NV),
    .OF         (OF),
    .UF         (UF),
    .NX         (NX),
    .ready      (ready)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(logic [23:0] m, logic [9:0] e, logic sg,
                       logic r, logic st, logic iv, logic fr,
                       logic [2:0] mode);
    @(negedge clk);
    man        = m;
    Exp        = e;
    sgn        = sg;
    round_bit  = r;
    sticky_bit = st;
    IV         = iv;
    final_res  = fr;
    rm         = mode;
    load       = 1'b1;
    @(negedge clk);
    load       = 1'b0;
    final_res  = 1'b0;
  endtask

  task automatic run(string tag, logic [23:0] m, logic [9:0] e,
                     logic sg, logic r, logic st, logic iv,
                     logic fr, logic [2:0] mode,
                     logic [31:0] x_out, logic [3:0] x_fl,
                     int x_lat);
    int lat;
    drive(m, e, sg, r, st, iv, fr, mode);
    lat = 1;
    while (ready !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ":lat"}, lat, x_lat);
    chk({tag, ":out"}, float_out, x_out);
    chk({tag, ":flags"}, {28'd0, NV, OF, UF, NX}, {28'd0, x_fl});
    @(negedge clk);
    chk({tag, ":pulse"}, {31'd0, ready}, 32'd0);
    chk({tag, ":hold"}, float_out, x_out);
  endtask

  task automatic no_ready(string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ready === 1'b1) seen = 1'b1;
    end
    chk({tag, ":noready"}, {31'd0, seen}, 32'd0);
    chk({tag, ":out"}, float_out, 32'd0);
    chk({tag, ":flags"}, {28'd0, NV, OF, UF, NX}, 32'd0);
  endtask

  initial begin
    n_reset    = 1'b0;
    kill       = 1'b0;
    load       = 1'b0;
    man        = '0;
    Exp        = '0;
    sgn        = 1'b0;
    round_bit  = 1'b0;
    sticky_bit = 1'b0;
    IV         = 1'b0;
    final_res  = 1'b0;
    rm         = '0;
    repeat (3) @(negedge clk);
    chk("rst:out", float_out, 32'd0);
    chk("rst:flags", {27'd0, NV, OF, UF, NX, ready}, 32'd0);
    n_reset = 1'b1;

    run("basic", 24'h800000, 10'd1, 0, 0, 0, 0, 0, 3'd0,
        32'h40000000, 4'b0000, 2);
    run("carry_rne", 24'hFFFFFF, 10'd0, 0, 1, 0, 0, 0, 3'd0,
        32'h40000000, 4'b0001, 2);
    run("carry_rtz", 24'hFFFFFF, 10'd0, 0, 1, 0, 0, 0, 3'd1,
        32'h3FFFFFFF, 4'b0001, 2);
    run("ovf_rne", 24'h800000, 10'd128, 0, 0, 0, 0, 0, 3'd0,
        32'h7F800000, 4'b0101, 2);
    run("ovf_rtz", 24'h800000, 10'd128, 0, 0, 0, 0, 0, 3'd1,
        32'h7F7FFFFF, 4'b0101, 2);
    run("ovf_rdn_neg", 24'h800000, 10'd128, 1, 0, 0, 0, 0, 3'd2,
        32'hFF800000, 4'b0101, 2);
    run("ovf_rup_neg", 24'h800000, 10'd128, 1, 0, 0, 0, 0, 3'd3,
        32'hFF7FFFFF, 4'b0101, 2);
    run("den_even", 24'h800001, -10'sd127, 0, 0, 0, 0, 0, 3'd0,
        32'h00400000, 4'b0011, 2);
    run("final", 24'hC00000, 10'h0FF, 0, 0, 0, 1, 1, 3'd0,
        32'h7FC00000, 4'b1000, 1);
    run("rdn_neg", 24'h800000, 10'd0, 1, 0, 1, 0, 0, 3'd2,
        32'hBF800001, 4'b0001, 2);
    run("rup_neg", 24'h800000, 10'd0, 1, 0, 1, 0, 0, 3'd3,
        32'hBF800000, 4'b0001, 2);
    run("rmm_tie", 24'h800000, 10'd0, 0, 1, 0, 0, 0, 3'd4,
        32'h3F800001, 4'b0001, 2);
    run("rne_tie", 24'h800000, 10'd0, 0, 1, 0, 0, 0, 3'd0,
        32'h3F800000, 4'b0001, 2);
    run("rm7_odd", 24'h800001, 10'd0, 0, 1, 0, 0, 0, 3'd7,
        32'h3F800002, 4'b0001, 2);
    run("iv_round", 24'h800000, 10'd1, 0, 0, 0, 1, 0, 3'd0,
        32'h40000000, 4'b1000, 2);
    run("den_exact", 24'h800000, -10'sd130, 0, 0, 0, 0, 0, 3'd0,
        32'h00080000, 4'b0000, 5);
    run("den_to_norm", 24'hFFFFFF, -10'sd127, 0, 0, 0, 0, 0, 3'd0,
        32'h00800000, 4'b0011, 2);
    run("den_cap", 24'h800000, -10'sd300, 0, 0, 0, 0, 0, 3'd3,
        32'h00000001, 4'b0011, 27);

    drive(24'h800000, -10'sd140, 0, 0, 0, 0, 0, 3'd0);
    @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    no_ready("kill");
    run("after_kill", 24'h800000, 10'd1, 0, 0, 0, 0, 0, 3'd0,
        32'h40000000, 4'b0000, 2);

    drive(24'h800000, -10'sd140, 0, 0, 0, 0, 0, 3'd0);
    @(negedge clk);
    run("restart", 24'hFFFFFF, 10'd0, 0, 1, 0, 0, 0, 3'd1,
        32'h3FFFFFFF, 4'b0001, 2);

    drive(24'h800000, -10'sd140, 0, 0, 0, 0, 0, 3'd0);
    @(negedge clk);
    n_reset = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    no_ready("rst_mid");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
